// File: rtl/pll_wb_pkg.sv
// pll_wb_pkg: shared types, widths and EHXPLLJ register map for the PLL Wishbone reconfiguration path
package pll_wb_pkg;
  localparam int PLL_ADDR_W = 5;
  localparam int PLL_DATA_W = 8;
  localparam logic [PLL_DATA_W-1:0] FULL_MASK = 8'hFF;
  typedef enum logic [2:0] {IDLE, RD_STB, GAP, WR_STB, RESP} state_t;
  localparam logic [PLL_ADDR_W-1:0] REG_CLKI_DIV  = 5'h00;
  localparam logic [PLL_ADDR_W-1:0] REG_CLKFB_DIV = 5'h01;
  localparam logic [PLL_ADDR_W-1:0] REG_CLKOP_DIV = 5'h02;
  localparam logic [PLL_ADDR_W-1:0] REG_CLKOK_DIV = 5'h03;
  localparam logic [PLL_ADDR_W-1:0] REG_PHASE     = 5'h04;
  localparam logic [PLL_ADDR_W-1:0] REG_DUTY      = 5'h05;
  localparam logic [PLL_ADDR_W-1:0] REG_CTRL      = 5'h08;
  localparam logic [PLL_ADDR_W-1:0] REG_STATUS    = 5'h09;
  function automatic logic [PLL_DATA_W-1:0] rmw_merge(input logic [PLL_DATA_W-1:0] cur, data, mask);
    return (cur & ~mask) | (data & mask);
  endfunction
endpackage

// File: rtl/pll_wb_ack_timer.sv
// pll_wb_ack_timer: loadable down-counter shared by the ack timeout and the inter-cycle gap
module pll_wb_ack_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       en,
  output logic       expired
);
  logic [7:0] cnt;
  always_ff @(posedge clk)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (clr) cnt <= '0;
    else if (en && cnt != '0) cnt <= cnt - 8'd1;
  assign expired = cnt == '0;
endmodule

// File: rtl/pll_wb_reconfig.sv
// pll_wb_reconfig: turns single read/write/masked-write requests into EHXPLLJ Wishbone config cycles
module pll_wb_reconfig
  import pll_wb_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16,
  parameter int GAP_CYCLES  = 1
) (
  input  logic                  PLLCLK,
  input  logic                  PLLRST_N,
  input  logic                  REQ_VALID,
  output logic                  REQ_READY,
  input  logic                  REQ_WE,
  input  logic [PLL_ADDR_W-1:0] REQ_ADDR,
  input  logic [PLL_DATA_W-1:0] REQ_DATA,
  input  logic [PLL_DATA_W-1:0] REQ_MASK,
  output logic                  RSP_VALID,
  output logic [PLL_DATA_W-1:0] RSP_DATA,
  output logic                  RSP_ERR,
  output logic                  BUSY,
  output logic                  PLLSTB,
  output logic                  PLLWE,
  output logic [PLL_ADDR_W-1:0] PLLADDR,
  output logic [PLL_DATA_W-1:0] PLLDATI,
  input  logic [PLL_DATA_W-1:0] PLLDATO,
  input  logic                  PLLACK
);
  state_t state, nxt;
  logic we_q, rmw_gap, rmw_gap_n, acc, in_stb, rd_ack, wr_ack, tmo, expired, load;
  logic [7:0] load_val;
  logic [PLL_DATA_W-1:0] data_q, mask_q, cap, cap_n, rsp_data_n, dati_n;
  logic [PLL_ADDR_W-1:0] addr_n;
  assign acc    = REQ_VALID && REQ_READY;
  assign in_stb = state == RD_STB || state == WR_STB;
  assign rd_ack = state == RD_STB && PLLACK;
  assign wr_ack = state == WR_STB && PLLACK;
  // an ack sampled on the last allowed strobe cycle beats the timeout
  assign tmo    = in_stb && !PLLACK && expired;
  pll_wb_ack_timer u_timer (
    .clk      (PLLCLK),
    .rst_n    (PLLRST_N),
    .clr      (state == IDLE),
    .load     (load),
    .load_val (load_val),
    .en       (1'b1),
    .expired  (expired)
  );
  always_ff @(posedge PLLCLK)
    if (!PLLRST_N) begin
      state     <= IDLE;
      REQ_READY <= 1'b0;
      BUSY      <= 1'b0;
      PLLSTB    <= 1'b0;
      PLLWE     <= 1'b0;
      RSP_VALID <= 1'b0;
      RSP_ERR   <= 1'b0;
      RSP_DATA  <= '0;
      PLLADDR   <= '0;
      PLLDATI   <= '0;
      cap       <= '0;
      rmw_gap   <= 1'b0;
      we_q      <= 1'b0;
      data_q    <= '0;
      mask_q    <= '0;
    end else begin
      state     <= nxt;
      REQ_READY <= nxt == IDLE;
      BUSY      <= nxt != IDLE;
      PLLSTB    <= nxt == RD_STB || nxt == WR_STB;
      PLLWE     <= nxt == WR_STB;
      RSP_VALID <= nxt == RESP;
      RSP_ERR   <= nxt == RESP && tmo;
      RSP_DATA  <= rsp_data_n;
      PLLADDR   <= addr_n;
      PLLDATI   <= dati_n;
      cap       <= cap_n;
      rmw_gap   <= rmw_gap_n;
      if (acc) begin
        we_q   <= REQ_WE;
        data_q <= REQ_DATA;
        mask_q <= REQ_MASK;
      end
    end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = acc ? ((REQ_WE && REQ_MASK == FULL_MASK) ? WR_STB : RD_STB) : IDLE;
      RD_STB:  nxt = PLLACK ? (we_q ? GAP : RESP) : expired ? RESP : RD_STB;
      GAP:     nxt = expired ? (rmw_gap ? WR_STB : IDLE) : GAP;
      WR_STB:  nxt = (PLLACK || expired) ? RESP : WR_STB;
      RESP:    nxt = GAP;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    cap_n      = rd_ack ? PLLDATO : cap;
    rsp_data_n = (rd_ack && !we_q) ? PLLDATO : wr_ack ? PLLDATI : tmo ? cap : RSP_DATA;
    // the merged value is staged on PLLDATI during the gap, while the strobe is low
    dati_n     = acc ? REQ_DATA : (rd_ack && we_q) ? rmw_merge(PLLDATO, data_q, mask_q) : PLLDATI;
    addr_n     = acc ? REQ_ADDR : PLLADDR;
    rmw_gap_n  = state == RD_STB ? 1'b1 : state == GAP ? rmw_gap : 1'b0;
    load       = nxt != state;
    load_val   = nxt == GAP ? 8'(GAP_CYCLES - 1) : 8'(ACK_TIMEOUT - 1);
  end
endmodule

// File: tb/tb_pll_wb_reconfig.sv
// tb_pll_wb_reconfig: randomized requests against a PLL register model with a response scoreboard
module tb_pll_wb_reconfig;
  localparam int T = 16;
  localparam int G = 2;
  typedef struct {logic err; logic [7:0] data;} rsp_t;
  typedef struct {int kind; logic [4:0] addr;} txn_t;
  logic PLLCLK = 0, PLLRST_N = 0, REQ_VALID = 0, REQ_WE = 0;
  logic [4:0] REQ_ADDR = 0;
  logic [7:0] REQ_DATA = 0, REQ_MASK = 0;
  logic REQ_READY, RSP_VALID, RSP_ERR, BUSY, PLLSTB, PLLWE, PLLACK;
  logic [7:0] RSP_DATA, PLLDATI, PLLDATO;
  logic [4:0] PLLADDR;
  rsp_t exp_q[$];
  txn_t kq[$];
  int dly_q[$];
  logic [7:0] ref_mem[32], pll_mem[32];
  int n_tests = 0, n_fail = 0;
  bit stray_en = 0;

  pll_wb_reconfig #(.ACK_TIMEOUT(T), .GAP_CYCLES(G)) dut (
    .PLLCLK(PLLCLK), .PLLRST_N(PLLRST_N), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_WE(REQ_WE), .REQ_ADDR(REQ_ADDR), .REQ_DATA(REQ_DATA), .REQ_MASK(REQ_MASK),
    .RSP_VALID(RSP_VALID), .RSP_DATA(RSP_DATA), .RSP_ERR(RSP_ERR), .BUSY(BUSY),
    .PLLSTB(PLLSTB), .PLLWE(PLLWE), .PLLADDR(PLLADDR), .PLLDATI(PLLDATI),
    .PLLDATO(PLLDATO), .PLLACK(PLLACK));

  always #5 PLLCLK = ~PLLCLK;

  // PLL model: acks each strobe after the delay queued for it, never if none was queued
  initial begin
    int stb_cyc = 0, cur_dly = 0;
    for (int i = 0; i < 32; i++) pll_mem[i] = 8'(i * 37 + 5);
    PLLACK = 0;
    PLLDATO = 0;
    forever begin
      @(posedge PLLCLK); #1;
      if (PLLSTB) begin
        stb_cyc++;
        if (stb_cyc == 1) cur_dly = dly_q.size() > 0 ? dly_q.pop_front() : 1000;
        PLLACK = stb_cyc == cur_dly;
        PLLDATO = PLLACK ? pll_mem[PLLADDR] : 8'($urandom);
        if (PLLACK && PLLWE) pll_mem[PLLADDR] = PLLDATI;
      end else begin
        stb_cyc = 0;
        PLLACK = stray_en && $urandom_range(0, 3) == 0;
        PLLDATO = 8'($urandom);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // protocol monitor and response scoreboard
  bit r1 = 1, r2 = 1, p_acc = 0, p_stb = 0, p_ack = 0, p_we = 0, p_rsp = 0, wexp;
  logic [13:0] p_sig;
  int low_cnt = 100, run = 0, strobes = 0;
  txn_t cur;
  rsp_t e;
  always @(negedge PLLCLK) begin
    if (!r1) begin
      chk("reset_vals", {REQ_READY, RSP_VALID, RSP_ERR, BUSY, PLLSTB, PLLWE, RSP_DATA, PLLADDR, PLLDATI}, 0);
      low_cnt = 100;
      run = 0;
    end else begin
      if (!r2) chk("ready_after_rst", REQ_READY, 1);
      if (p_acc) begin
        chk("accept_stb", {PLLSTB, BUSY, REQ_READY}, 3'b110);
        if (kq.size() > 0) cur = kq.pop_front();
        else chk("accept_unexpected", 1, 0);
        strobes = 0;
      end
      if (p_stb && p_ack) begin
        chk("stb_drop", PLLSTB, 0);
        chk("rsp_after_ack", RSP_VALID, 32'(p_we || cur.kind == 0));
      end
      if (p_stb && !p_ack) begin
        if (PLLSTB) chk("stb_stable", {PLLWE, PLLADDR, PLLDATI}, p_sig);
        else begin
          chk("tmo_len", run, T);
          chk("tmo_rsp", {RSP_VALID, RSP_ERR}, 2'b11);
        end
      end
      if (PLLSTB && !p_stb) begin
        strobes++;
        chk("gap", 32'((cur.kind == 2 && strobes == 2) ? low_cnt == G : low_cnt >= G), 1);
        wexp = cur.kind == 1 || strobes == 2;
        chk("stb_addr_we", {PLLADDR, PLLWE}, {cur.addr, wexp});
      end
      if (p_rsp) chk("rsp_pulse", RSP_VALID, 0);
      if (RSP_VALID) begin
        if (exp_q.size() == 0) chk("rsp_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("rsp_err", RSP_ERR, e.err);
          if (!e.err) chk("rsp_data", RSP_DATA, e.data);
        end
      end
      if (PLLSTB) run = p_stb ? run + 1 : 1;
      else low_cnt = p_stb ? 1 : low_cnt + 1;
    end
    r2 = r1;
    r1 = PLLRST_N;
    p_acc = REQ_VALID && REQ_READY && PLLRST_N;
    p_stb = PLLSTB && PLLRST_N;
    p_ack = PLLACK;
    p_we = PLLWE;
    p_rsp = RSP_VALID && PLLRST_N;
    p_sig = {PLLWE, PLLADDR, PLLDATI};
  end

  // queue the expected outcome from register-level semantics, then present the request
  task automatic send(input bit we, input logic [4:0] a, input logic [7:0] d, m,
                      input int rd_d, wr_d, input bit track);
    rsp_t r;
    txn_t t;
    t.addr = a;
    t.kind = !we ? 0 : (m == 8'hFF) ? 1 : 2;
    if (track) begin
      if (t.kind == 1) begin
        dly_q.push_back(wr_d);
        r.err = wr_d > T;
        r.data = d;
        if (!r.err) ref_mem[a] = d;
      end else begin
        dly_q.push_back(rd_d);
        r.err = rd_d > T;
        r.data = ref_mem[a];
        if (t.kind == 2 && !r.err) begin
          r.data = (ref_mem[a] & ~m) | (d & m);
          dly_q.push_back(wr_d);
          r.err = wr_d > T;
          if (!r.err) ref_mem[a] = r.data;
        end
      end
      exp_q.push_back(r);
    end
    kq.push_back(t);
    REQ_VALID = 1; REQ_WE = we; REQ_ADDR = a; REQ_DATA = d; REQ_MASK = m;
    for (int i = 0; i < 100 && !REQ_READY; i++) begin @(posedge PLLCLK); #1; end
    if (!REQ_READY) begin
      $display("FAIL accept_wait: REQ_READY stayed 0, expected 1");
      $fatal(1);
    end
    @(posedge PLLCLK); #1;
    REQ_VALID = 0; REQ_DATA = 8'($urandom); REQ_MASK = 8'($urandom);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (exp_q.size() > 0 || BUSY); i++) begin @(posedge PLLCLK); #1; end
    if (exp_q.size() > 0 || BUSY) begin
      $display("FAIL drain: %0d responses outstanding, BUSY=%0b, expected 0 and 0", exp_q.size(), BUSY);
      $fatal(1);
    end
  endtask

  function automatic int pick();
    int r = $urandom_range(0, 9);
    return r == 0 ? T + 5 : r == 1 ? T : $urandom_range(1, 5);
  endfunction

  initial begin
    int r;
    for (int i = 0; i < 32; i++) ref_mem[i] = 8'(i * 37 + 5);
    repeat (3) @(posedge PLLCLK);
    #1 PLLRST_N = 1;
    send(0, 5'h07, 8'h00, 8'h00, 3, 0, 1);
    send(1, 5'h04, 8'h23, 8'hFF, 0, 2, 1);
    send(1, 5'h09, 8'hF0, 8'hFF, 0, 1, 1);
    send(1, 5'h09, 8'h0F, 8'h3C, 2, 3, 1);
    send(0, 5'h02, 8'h00, 8'h00, T + 5, 0, 1);
    send(0, 5'h02, 8'h00, 8'h00, 1, 0, 1);
    send(0, 5'h09, 8'h00, 8'h00, T, 0, 1);
    send(1, 5'h0A, 8'h55, 8'h00, 1, T, 1);
    send(1, 5'h0B, 8'h55, 8'h0F, T + 5, 1, 1);
    send(1, 5'h0B, 8'hAA, 8'hF0, 2, T + 5, 1);
    send(0, 5'h0B, 8'h00, 8'h00, 2, 0, 1);
    stray_en = 1;
    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 3);
      send(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 8'($urandom),
           r == 0 ? 8'hFF : r == 1 ? 8'h00 : 8'($urandom), pick(), pick(), 1);
      if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 6)) @(posedge PLLCLK);
      #1;
    end
    drain();
    send(1, 5'h11, 8'hAB, 8'hFF, 0, 0, 0);
    repeat (3) @(posedge PLLCLK);
    #1 PLLRST_N = 0;
    @(posedge PLLCLK);
    #1 PLLRST_N = 1;
    repeat (3) @(posedge PLLCLK);
    #1;
    send(0, 5'h11, 8'h00, 8'h00, 2, 0, 1);
    drain();
    repeat (4) @(posedge PLLCLK);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
